// File: rtl/pot_pkg.sv
// rtl/pot_pkg.sv - shared widths, weight-code fields and FSM states for the PoT shift MAC
package pot_pkg;

    typedef enum logic {
        ST_ACC    = 1'b0,
        ST_RESULT = 1'b1
    } pot_state_t;

    // The all-zero-exponent negative code is reserved to mean "weight is zero".
    localparam logic POT_ZERO_SIGN = 1'b1;
    localparam int   POT_ZERO_EXP  = 0;
    localparam int   POT_EXP_LSB   = 0;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int pot_sign_idx(input int ww);
        return ww - 1;
    endfunction

    function automatic int pot_shift_max(input int ww);
        return (1 << (ww - 1)) - 1;
    endfunction

    function automatic int pot_prod_width(input int iw, input int ww);
        return iw + pot_shift_max(ww) + 1;
    endfunction

endpackage

// File: rtl/pot_shift_lane.sv
// rtl/pot_shift_lane.sv - one lane: decode PoT weight, extend activation, shift and negate
module pot_shift_lane
    import pot_pkg::*;
#(
    parameter int IW           = 8,
    parameter int WW           = 4,
    parameter int INPUT_SIGNED = 0,
    parameter int PROD_W       = 16
)(
    input  logic [IW-1:0]            i_act,
    input  logic [WW-1:0]            i_weight,
    output logic signed [PROD_W-1:0] o_prod
);

    logic                     w_sign;
    logic [WW-2:0]            w_exp;
    logic                     w_fill;
    logic                     w_zero;
    logic signed [PROD_W-1:0] w_ext;
    logic signed [PROD_W-1:0] w_shift;

    assign w_sign  = i_weight[pot_sign_idx(WW)];
    assign w_exp   = i_weight[pot_sign_idx(WW)-1:POT_EXP_LSB];
    assign w_fill  = (INPUT_SIGNED != 0) ? i_act[IW-1] : 1'b0;
    assign w_ext   = {{(PROD_W-IW){w_fill}}, i_act};
    assign w_shift = w_ext << w_exp;
    assign w_zero  = (w_sign == POT_ZERO_SIGN) && (w_exp == (WW-1)'(POT_ZERO_EXP));

    assign o_prod = w_zero ? '0 : (w_sign ? -w_shift : w_shift);

endmodule

// File: rtl/pot_shift_mac.sv
// rtl/pot_shift_mac.sv - multi-lane PoT dot-product MAC; POT_MAC_SAT_EN enables saturating accumulate
module pot_shift_mac
    import pot_pkg::*;
#(
    parameter int INPUT_BIT_WIDTH  = 8,
    parameter int WEIGHT_BIT_WIDTH = 4,
    parameter int INPUT_SIGNED     = 0,
    parameter int LANES            = 4,
    parameter int VEC_LEN          = 16,
    parameter int ACC_BIT_WIDTH    = pot_prod_width(INPUT_BIT_WIDTH, WEIGHT_BIT_WIDTH)
                                     + clog2(LANES) + clog2(VEC_LEN)
)(
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [LANES*INPUT_BIT_WIDTH-1:0]     in_data,
    input  logic [LANES*WEIGHT_BIT_WIDTH-1:0]    in_weight,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [ACC_BIT_WIDTH-1:0]             out_data,
    output logic                                 out_overflow
);

    localparam int IW     = INPUT_BIT_WIDTH;
    localparam int WW     = WEIGHT_BIT_WIDTH;
    localparam int ACC_W  = ACC_BIT_WIDTH;
    localparam int PROD_W = pot_prod_width(IW, WW);
    localparam int SUM_W  = PROD_W + clog2(LANES);
    localparam int CNT_W  = (VEC_LEN > 1) ? clog2(VEC_LEN) : 1;

    pot_state_t               r_state;
    pot_state_t               w_state_next;
    logic                     w_en;
    logic                     w_accept;
    logic                     w_last_beat;
    logic [CNT_W-1:0]         r_beat_cnt;
    logic                     r_s1_valid;
    logic                     r_s1_last;
    logic signed [PROD_W-1:0] w_prod [LANES];
    logic signed [PROD_W-1:0] r_prod [LANES];
    logic signed [SUM_W-1:0]  w_sum;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic [ACC_W-1:0]         r_out_data;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        pot_shift_lane #(
            .IW           (IW),
            .WW           (WW),
            .INPUT_SIGNED (INPUT_SIGNED),
            .PROD_W       (PROD_W)
        ) u_lane (
            .i_act    (in_data[l*IW +: IW]),
            .i_weight (in_weight[l*WW +: WW]),
            .o_prod   (w_prod[l])
        );
    end

    assign w_accept    = in_valid & w_en;
    assign w_last_beat = (r_beat_cnt == CNT_W'(VEC_LEN - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ACC: begin
                if (r_s1_valid && r_s1_last) begin
                    w_state_next = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (out_ready) begin
                    w_state_next = (r_s1_valid && r_s1_last) ? ST_RESULT : ST_ACC;
                end
            end
            default: w_state_next = ST_ACC;
        endcase
    end

    // A pending result blocks the whole pipe until downstream takes it.
    always_comb begin
        out_valid = (r_state == ST_RESULT);
        w_en      = (r_state == ST_ACC) | out_ready;
        in_ready  = w_en;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_beat_cnt <= '0;
            for (int l = 0; l < LANES; l++) begin
                r_prod[l] <= '0;
            end
        end else if (w_en) begin
            r_s1_valid <= in_valid;
            r_s1_last  <= in_valid & w_last_beat;
            if (in_valid) begin
                for (int l = 0; l < LANES; l++) begin
                    r_prod[l] <= w_prod[l];
                end
                r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            w_sum = w_sum + SUM_W'(r_prod[l]);
        end
    end

`ifdef POT_MAC_SAT_EN
    localparam int WIDE_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;

    logic signed [WIDE_W-1:0] w_acc_wide;
    logic signed [WIDE_W-1:0] w_sat_max;
    logic signed [WIDE_W-1:0] w_sat_min;
    logic                     w_ovf_step;
    logic                     r_ovf_sticky;
    logic                     r_out_ovf;

    assign w_sat_max  = {{(WIDE_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    assign w_sat_min  = {{(WIDE_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    assign w_acc_wide = WIDE_W'(r_acc) + WIDE_W'(w_sum);

    always_comb begin
        w_ovf_step = 1'b0;
        w_acc_next = w_acc_wide[ACC_W-1:0];
        if (w_acc_wide > w_sat_max) begin
            w_ovf_step = 1'b1;
            w_acc_next = w_sat_max[ACC_W-1:0];
        end else if (w_acc_wide < w_sat_min) begin
            w_ovf_step = 1'b1;
            w_acc_next = w_sat_min[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf_sticky <= 1'b0;
            r_out_ovf    <= 1'b0;
        end else if (w_en && r_s1_valid) begin
            if (r_s1_last) begin
                r_out_ovf    <= r_ovf_sticky | w_ovf_step;
                r_ovf_sticky <= 1'b0;
            end else begin
                r_ovf_sticky <= r_ovf_sticky | w_ovf_step;
            end
        end
    end

    assign out_overflow = r_out_ovf;
`else
    assign w_acc_next   = r_acc + ACC_W'(w_sum);
    assign out_overflow = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_out_data <= '0;
        end else if (w_en && r_s1_valid) begin
            if (r_s1_last) begin
                r_out_data <= w_acc_next;
                r_acc      <= '0;
            end else begin
                r_acc      <= w_acc_next;
            end
        end
    end

    assign out_data = r_out_data;

endmodule

// File: tb/tb_pot_shift_mac.sv
// tb/tb_pot_shift_mac.sv - self-checking bench: default, signed-input and 16-bit-accumulator instances
module tb_pot_shift_mac;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_data;
    logic [15:0] in_weight;

    logic        in_ready0, in_ready1, in_ready2;
    logic        out_valid0, out_valid1, out_valid2;
    logic [21:0] out_data0, out_data1;
    logic [15:0] out_data2;
    logic        out_ovf0, out_ovf1, out_ovf2;

    int n_chk = 0;
    int n_err = 0;

    longint q0[$];
    longint q1[$];
    longint q2[$];
    longint q2o[$];
    longint m_acc0, m_acc1, m_acc2;
    bit     m_ovf2;
    int     m_beats;

    logic   ob_v0;
    longint ob_d0, last_d0, last_d1, last_d2, last_o2;
    logic   ob_rdy;

    always #5 clk = ~clk;

    pot_shift_mac u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_weight(in_weight), .out_valid(out_valid0),
        .out_ready(out_ready), .out_data(out_data0), .out_overflow(out_ovf0)
    );

    pot_shift_mac #(.INPUT_SIGNED(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_weight(in_weight), .out_valid(out_valid1),
        .out_ready(out_ready), .out_data(out_data1), .out_overflow(out_ovf1)
    );

    pot_shift_mac #(.ACC_BIT_WIDTH(16)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_weight(in_weight), .out_valid(out_valid2),
        .out_ready(out_ready), .out_data(out_data2), .out_overflow(out_ovf2)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint lane_val(input bit sgn, input logic [7:0] a, input logic [3:0] w);
        longint av;
        logic [2:0] e;
        e  = w[2:0];
        av = sgn ? longint'($signed(a)) : longint'(a);
        if (w[3] && e == 3'd0) return 0;
        av = av * (longint'(1) << e);
        return w[3] ? -av : av;
    endfunction

    function automatic longint wrap(input longint v, input int w);
        longint m;
        m = v & ((longint'(1) << w) - 1);
        if (m >= (longint'(1) << (w - 1))) m = m - (longint'(1) << w);
        return m;
    endfunction

    task automatic model_clear();
        m_acc0 = 0; m_acc1 = 0; m_acc2 = 0; m_ovf2 = 0; m_beats = 0;
        q0.delete(); q1.delete(); q2.delete(); q2o.delete();
    endtask

    task automatic model_accept(input logic [31:0] d, input logic [15:0] w);
        longint su, ss, t;
        su = 0; ss = 0;
        for (int l = 0; l < 4; l++) begin
            su += lane_val(1'b0, d[8*l +: 8], w[4*l +: 4]);
            ss += lane_val(1'b1, d[8*l +: 8], w[4*l +: 4]);
        end
        m_acc0 += su;
        m_acc1 += ss;
        t = m_acc2 + su;
`ifdef POT_MAC_SAT_EN
        if (t > 32767) begin t = 32767; m_ovf2 = 1; end
        else if (t < -32768) begin t = -32768; m_ovf2 = 1; end
`endif
        m_acc2 = t;
        m_beats++;
        if (m_beats == 16) begin
            q0.push_back(wrap(m_acc0, 22));
            q1.push_back(wrap(m_acc1, 22));
            q2.push_back(wrap(m_acc2, 16));
            q2o.push_back(longint'(m_ovf2));
            m_acc0 = 0; m_acc1 = 0; m_acc2 = 0; m_ovf2 = 0; m_beats = 0;
        end
    endtask

    task automatic cycle(input logic v, input logic [31:0] d, input logic [15:0] w,
                         input logic rdy, output logic acc);
        longint e;
        @(negedge clk);
        in_valid = v; in_data = d; in_weight = w; out_ready = rdy;
        #1;
        ob_v0  = out_valid0;
        ob_d0  = longint'($signed(out_data0));
        ob_rdy = in_ready0;
        acc    = v & in_ready0;
        if (acc) model_accept(d, w);
        if (out_valid0 && rdy) begin
            check("res0_pending", longint'(q0.size() > 0), 1);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("res0_data", ob_d0, e);
                check("res0_ovf", longint'(out_ovf0), 0);
                last_d0 = ob_d0;
            end
        end
        if (out_valid1 && rdy) begin
            check("res1_pending", longint'(q1.size() > 0), 1);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                last_d1 = longint'($signed(out_data1));
                check("res1_data", last_d1, e);
                check("res1_ovf", longint'(out_ovf1), 0);
            end
        end
        if (out_valid2 && rdy) begin
            check("res2_pending", longint'(q2.size() > 0), 1);
            if (q2.size() > 0) begin
                e = q2.pop_front();
                last_d2 = longint'($signed(out_data2));
                last_o2 = longint'(out_ovf2);
                check("res2_data", last_d2, e);
                check("res2_ovf", last_o2, q2o.pop_front());
            end
        end
    endtask

    // rmode: 0/1 fixed out_ready, 2 random out_ready.
    task automatic send_beat(input logic [31:0] d, input logic [15:0] w, input int rmode,
                             output int tries);
        logic acc;
        logic rdy;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 100) begin
            rdy = (rmode == 2) ? logic'($urandom_range(0, 1)) : logic'(rmode);
            cycle(1'b1, d, w, rdy, acc);
            tries++;
        end
        check("send_accepted", longint'(acc), 1);
    endtask

    task automatic idle(input logic rdy);
        logic acc;
        cycle(1'b0, 32'h0, 16'h0, rdy, acc);
    endtask

    task automatic send_vec(input logic [31:0] d, input logic [15:0] w);
        int tries;
        for (int b = 0; b < 16; b++) send_beat(d, w, 1, tries);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() + q1.size() + q2.size()) > 0 && n < 50) begin
            idle(1'b1);
            n++;
        end
        check("drain_empty", longint'(q0.size() + q1.size() + q2.size()), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("rst_out_valid", longint'(out_valid0), 0);
        check("rst_out_data", longint'(out_data0), 0);
        check("rst_out_ovf2", longint'(out_ovf2), 0);
        check("rst_out_data2", longint'(out_data2), 0);
        rst_n = 1'b1;
        model_clear();
        idle(1'b1);
        check("rst_in_ready", longint'(ob_rdy), 1);
    endtask

    initial begin
        logic [31:0] d;
        logic [15:0] w;
        logic        acc;
        longint      held;
        int          tries;
        int          n;
        int          first_try;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0; in_weight = '0;
        model_clear();
        repeat (2) @(negedge clk);
        do_reset();

        // Unit-weight vector: latency and single-cycle result pulse.
        send_vec(32'h01010101, 16'h0000);
        idle(1'b1);
        check("t1_lat1_valid", longint'(ob_v0), 0);
        idle(1'b1);
        check("t1_lat2_valid", longint'(ob_v0), 1);
        check("t1_data", ob_d0, 64);
        idle(1'b1);
        check("t1_pulse", longint'(ob_v0), 0);

        // Max magnitude: exact in 22 bits, wraps or saturates in 16 bits.
        send_vec(32'hFFFFFFFF, 16'h7777);
        drain();
        check("t2_data", last_d0, 2088960);
`ifdef POT_MAC_SAT_EN
        check("t2_acc16_data", last_d2, 32767);
        check("t2_acc16_ovf", last_o2, 1);
`else
        check("t2_acc16_data", last_d2, -8192);
        check("t2_acc16_ovf", last_o2, 0);
`endif

        // Mixed signs including the zero code.
        send_vec(32'h03030303, 16'h8B29);
        drain();
        check("t3_data", last_d0, -288);
        send_vec(32'h80808080, 16'hFFFF);
        drain();
        check("t3_signed_data", last_d1, 1048576);

        // Random gaps, result held under backpressure, then a second vector.
        for (int b = 0; b < 16; b++) begin
            n = $urandom_range(0, 2);
            for (int g = 0; g < n; g++) idle(1'b0);
            send_beat($urandom, 16'($urandom), 0, tries);
        end
        n = 0;
        idle(1'b0);
        while (!ob_v0 && n < 10) begin
            idle(1'b0);
            n++;
        end
        check("t4_result_seen", longint'(ob_v0), 1);
        held = ob_d0;
        d = $urandom;
        w = 16'($urandom);
        for (int h = 0; h < 5; h++) begin
            cycle(1'b1, d, w, 1'b0, acc);
            check("t4_hold_in_ready", longint'(ob_rdy), 0);
            check("t4_hold_data", ob_d0, held);
            check("t4_hold_valid", longint'(ob_v0), 1);
        end
        send_beat(d, w, 2, tries);
        for (int b = 1; b < 16; b++) begin
            if ($urandom_range(0, 3) == 0) idle(1'b1);
            send_beat($urandom, 16'($urandom), 2, tries);
        end
        drain();

        // Back-to-back vectors with continuous valid must never stall.
        first_try = 0;
        for (int b = 0; b < 32; b++) begin
            send_beat($urandom, 16'($urandom), 1, tries);
            if (tries == 1) first_try++;
        end
        check("t4_full_tput", longint'(first_try), 32);
        drain();

        // Reset mid-vector discards the partial sum.
        for (int b = 0; b < 6; b++) send_beat(32'hFFFFFFFF, 16'h7777, 1, tries);
        do_reset();
        check("t5_valid_after_rst", longint'(ob_v0), 0);
        send_vec(32'h01010101, 16'h0000);
        drain();
        check("t5_data", last_d0, 64);

        idle(1'b1);
        check("end_valid_low", longint'(ob_v0), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
